stream_pool2x2: RTL
===================

// Module: stream_pool2x2
// PURPOSE
//  Parametrised streaming 2x2/stride-2 pooling stage for the ML accelerator datapath.
//  Consumes conv-engine output pixels in raster order over a valid/ready stream.
//  Emits one pooled pixel per 2x2 window, also in raster order, with a last-of-frame flag.
//  Replaces fixed 4-pixel pooling: any even frame size, backpressure, optional average mode.
// PARAMETERS
//  DATA_W  8  pixel width, unsigned
//  IMG_W   4  input frame width in pixels; must be even and >=2 (elaboration $error otherwise)
//  IMG_H   4  input frame height in pixels; must be even and >=2 (elaboration $error otherwise)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       input pixel valid
//  in_ready   out  1       block can accept input pixel
//  in_data    in   DATA_W  conv result pixel
//  out_valid  out  1       pooled pixel valid
//  out_ready  in   1       downstream accepts pooled pixel
//  out_data   out  DATA_W  pooled pixel
//  out_last   out  1       qualifies out_data as last pooled pixel of frame
//  avg_mode   in   1       (POOL_AVG_EN only) 1=average, 0=max
// BEHAVIOUR
//  - One clock (clk), synchronous active-high reset (rst); no other clock or reset.
//  - Reset: out_valid=0, out_data=0, out_last=0, col=0, row=0, h_reg=0; line buffer not cleared.
//  - Beat accepted when in_valid&&in_ready; out beat when out_valid&&out_ready.
//  - in_ready = !out_valid || out_ready (combinational); stalls all inputs while output blocked.
//  - Counters: col 0..IMG_W-1, row 0..IMG_H-1, advance per accepted input beat only.
//  - col wraps to 0 and row increments; at (IMG_W-1, IMG_H-1) both wrap to 0.
//  - Even col: h_reg <= in_data.
//  - Odd col: h = combine(h_reg, in_data).
//  - Odd col, even row: linebuf[col>>1] <= h.
//  - Odd col, odd row: out_data <= combine(linebuf[col>>1], h).
//  - Odd col, odd row: out_valid <= 1; out_last <= (row==IMG_H-1 && col==IMG_W-1).
//  - Latency: out_valid rises on the edge after the 4th pixel of a window is accepted.
//  - Out register: on out-accept with no new result, out_valid <= 0.
//  - Simultaneous out-accept and new result in the same cycle: reload, out_valid stays 1, no bubble.
//  - out_data/out_last hold stable while out_valid && !out_ready.
//  - combine (max mode): unsigned max; equal operands give that value.
//  - Throughput: 1 input pixel/cycle when not back-pressured; 1 output per 4 inputs.
//  - Reset mid-frame: partial window discarded, any pending output dropped; next beat is (0,0).
//  - in_valid low: no state change. in_data ignored when not accepted.
// CONFIGURATION
//  `define POOL_AVG_EN adds avg_mode port.
//   - avg_mode is sampled on accept of pixel (0,0) and held in mode_q for the whole frame.
//   - Average mode: h and linebuf entries are DATA_W+1-bit pair sums.
//   - Average mode: out_data = (lb + h) >> 2, truncating, from a DATA_W+2 sum; no saturation needed.
//   - Max mode is identical to the build without the macro.
//  Without POOL_AVG_EN: no avg_mode port; max only; linebuf entries are DATA_W bits.
// STRUCTURE
//  pool_pkg:
//   - localparam LB_DEPTH = IMG_W/2.
//   - typedef pool_mode_e {POOL_MAX, POOL_AVG}.
//   - function pool_combine(a, b, mode) covering both max and sum.
//  Sub-module pool_line_buf:
//   - LB_DEPTH x entry-width register array.
//   - 1 write port, 1 asynchronous read port addressed by col>>1.
//  Top: counters, h_reg, output register, handshake logic.
// TESTING
//  1. 4x4 max, no stall, pixels 0..15 raster -> outputs 5,7,13,15; out_last only on 15.
//  2. 4x4 max, out_ready=0 after first output -> in_ready=0, out_data=5 held; release -> 7,13,15 follow.
//  3. 6x4 max, in_valid toggled pseudo-randomly, all pixels 8'hFF except one 8'h00 per window
//     -> 6 outputs of 8'hFF, out_last on 6th.
//  4. rst pulsed after 6 pixels of frame 1, then full frame 0..15
//     -> out_valid=0 during reset; only 5,7,13,15 emitted.
//  5. POOL_AVG_EN, avg_mode=1 at (0,0), window {255,255,255,254}
//     -> 254 (1019>>2); avg_mode toggled mid-frame has no effect.
//  6. Back-to-back frames, out_ready=1 constant -> no bubble between frames; out_last once per frame.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and the combine operator for the 2x2 pooling stage.
package pool_pkg;

    localparam int POOL_CW   = 32;
    localparam int DEF_IMG_W = 4;
    localparam int LB_DEPTH  = DEF_IMG_W / 2;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Max returns the larger operand; average mode returns the full-width pair sum.
    function automatic logic [POOL_CW-1:0] pool_combine(
        input logic [POOL_CW-1:0] a,
        input logic [POOL_CW-1:0] b,
        input pool_mode_e         mode
    );
        if (mode == POOL_AVG) begin
            return a + b;
        end
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal pair results; one write port, asynchronous read.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = LB_DEPTH,
    parameter int EW    = 8,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_pool2x2.sv
// Streaming 2x2 stride-2 pooling over a raster valid/ready pixel stream.
// Define POOL_AVG_EN to add the avg_mode port and the averaging datapath.
module stream_pool2x2
    import pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef POOL_AVG_EN
    ,
    input  logic              avg_mode
`endif
);

    localparam int DEPTH = IMG_W / 2;
    localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef POOL_AVG_EN
    localparam int EW    = DATA_W + 1;
`else
    localparam int EW    = DATA_W;
`endif
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_w
        $error("stream_pool2x2: IMG_W must be even and >= 2");
    end
    if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_h
        $error("stream_pool2x2: IMG_H must be even and >= 2");
    end

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [EW-1:0]      h_reg;
    logic [EW-1:0]      h;
    logic [EW-1:0]      lb_rd;
    logic [POOL_CW-1:0] h_wide;
    logic [POOL_CW-1:0] v_wide;
    logic [DATA_W-1:0]  pooled;
    logic               accept;
    logic               frame_start;
    logic               lb_we;
    logic               unused_bits;
    pool_mode_e         mode;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign frame_start = (col == '0) && (row == '0);

`ifdef POOL_AVG_EN
    pool_mode_e mode_q;

    // Mode is taken live on the first pixel so that window already uses it.
    assign mode = frame_start ? (avg_mode ? POOL_AVG : POOL_MAX) : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= POOL_MAX;
        end else if (accept && frame_start) begin
            mode_q <= mode;
        end
    end
`else
    assign mode = POOL_MAX;
`endif

    assign h_wide = pool_combine(POOL_CW'(h_reg), POOL_CW'(in_data), mode);
    assign h      = h_wide[EW-1:0];
    assign v_wide = pool_combine(POOL_CW'(lb_rd), POOL_CW'(h), mode);
    assign pooled = (mode == POOL_AVG) ? v_wide[DATA_W+1:2] : v_wide[DATA_W-1:0];

    assign unused_bits = ^{h_wide[POOL_CW-1:EW], v_wide[POOL_CW-1:DATA_W+2]};

    assign lb_we = accept && col[0] && !row[0];

    pool_line_buf #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (AW'(col >> 1)),
        .wdata (h),
        .raddr (AW'(col >> 1)),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            h_reg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0]) begin
                    h_reg <= EW'(in_data);
                end
            end
            // A new result reloads the output register even while the old one is being taken.
            if (accept && col[0] && row[0]) begin
                out_valid <= 1'b1;
                out_data  <= pooled;
                out_last  <= (row == ROW_LAST) && (col == COL_LAST);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
